// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE stream sequencer.
// Holds the FSM state enum and pipeline/width defaults.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int PIPE_LAT_D = 3;
  localparam int CNT_W_D    = 10;
  localparam int PSUM_W_D   = 25;

endpackage

// File: rtl/pe_vld_pipe.sv
// Occupancy shift register tracking which PE slots hold real beats.
// Ports: clk, rst_n, clr_i, adv_i, acc_i in; vld_o[LAT-1:0] out.
module pe_vld_pipe #(
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           adv_i,
  input  logic           acc_i,
  output logic [LAT-1:0] vld_o
);

  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;

  always_comb begin
    vld_d = vld_q;
    if (clr_i) begin
      vld_d = '0;
    end else if (adv_i) begin
      // non-accepted advance shifts in a bubble
      vld_d = {vld_q[LAT-2:0], acc_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld_o = vld_q;

endmodule

// File: rtl/pe_stream_ctrl.sv
// Sequencer for one pipelined MAC PE: throttles ifm, drives stall,
// emits finished psums on valid/ready with per-job beat count.
// Ports: clk, rst_n, start, cfg_cols, in_valid, out_ready, pe_psum in;
// busy, done, in_ready, pe_stall, out_valid, out_psum, out_last out.
module pe_stream_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_D,
  parameter int CNT_W    = CNT_W_D,
  parameter int PSUM_W   = PSUM_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_cols,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pe_stall,
  input  logic [PSUM_W-1:0] pe_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_psum,
  output logic              out_last
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] cols_q, cols_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] outcnt_q, outcnt_d;

  logic [PIPE_LAT-1:0] vld;
  logic active, blocked, advance;
  logic accept, out_hs, idle;

  assign idle    = (state_q == S_IDLE);
  assign active  = (state_q == S_RUN) |
                   (state_q == S_DRAIN);
  // a full head slot can only leave by handshake
  assign blocked = vld[PIPE_LAT-1] & ~out_ready;
  assign advance = active & ~blocked;
  assign accept  = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;

  pe_vld_pipe #(
    .LAT (PIPE_LAT)
  ) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (idle),
    .adv_i (advance),
    .acc_i (accept),
    .vld_o (vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cols_q   <= '0;
      issued_q <= '0;
      outcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      issued_q <= issued_d;
      outcnt_q <= outcnt_d;
    end
  end

  always_comb begin
    cols_d   = cols_q;
    issued_d = issued_q;
    outcnt_d = outcnt_q;
    if (idle) begin
      issued_d = '0;
      outcnt_d = '0;
      if (start) cols_d = cfg_cols;
    end else begin
      if (accept) issued_d = issued_q + CNT_W'(1);
      if (out_hs) outcnt_d = outcnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_cols == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued_q == cols_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // look at next count so done follows the last handshake
        if (outcnt_d == cols_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_RUN: begin
        busy      = 1'b1;
        in_ready  = advance & (issued_q < cols_q);
        out_valid = vld[PIPE_LAT-1];
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = vld[PIPE_LAT-1];
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
    endcase
  end

  assign pe_stall = ~advance;
  assign out_psum = pe_psum;
  assign out_last = out_valid &
                    (outcnt_q == cols_q - CNT_W'(1));

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Self-checking bench for pe_stream_ctrl with a mock 3-stage PE.
// Scoreboard queue of accepted beats vs delivered psums.
module tb_pe_stream_ctrl;
  import pe_ctrl_pkg::*;

  localparam int CW  = 10;
  localparam int PW  = 25;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_cols = '0;
  logic          busy, done;
  logic          in_valid = 1'b0;
  logic          in_ready, pe_stall;
  logic [PW-1:0] pe_psum, out_psum;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;

  logic [PW-1:0] ifm_d = '0;
  logic [PW-1:0] p0 = '0, p1 = '0, p2 = '0;

  int checks = 0;
  int errors = 0;

  // job record
  int cyc, cols_m, acc_n, hs_n, done_n;
  int last_hs, last_cyc, done_cyc, busy_low;
  bit ir_seen, stall_run, hold_active;
  logic [PW-1:0] held;
  logic [PW-1:0] exp_q[$];
  int acc_cyc[$];
  int ov_cyc[$];

  always #5 clk = ~clk;

  // mock PE: frozen while stalled, p_sum = capture 3 advances ago
  always @(posedge clk) begin
    if (!pe_stall) begin
      p0 <= ifm_d;
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign pe_psum = p2;

  pe_stream_ctrl #(
    .PIPE_LAT (LAT),
    .CNT_W    (CW),
    .PSUM_W   (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_cols  (cfg_cols),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pe_stall  (pe_stall),
    .pe_psum   (pe_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
    .out_last  (out_last)
  );

  task automatic chk1(input string tag,
                      input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    acc_n = 0; hs_n = 0; done_n = 0;
    last_hs = -1; last_cyc = -1;
    done_cyc = -1; busy_low = -1;
    ir_seen = 0; stall_run = 0; hold_active = 0;
    exp_q.delete();
    acc_cyc.delete();
    ov_cyc.delete();
  endtask

  task automatic step();
    logic [PW-1:0] e;
    @(negedge clk);
    if (hold_active) begin
      chk1("hold_stall", pe_stall, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
      chkn("hold_psum", 32'(out_psum), 32'(held));
    end
    if (in_valid && in_ready) begin
      acc_n++;
      acc_cyc.push_back(cyc);
      exp_q.push_back(ifm_d);
    end
    if (in_ready) ir_seen = 1;
    if (busy && !done && out_ready && pe_stall)
      stall_run = 1;
    if (out_valid) ov_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      chk1("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chkn("psum", 32'(out_psum), 32'(e));
      end
      chk1("last", out_last, hs_n == cols_m - 1);
      hs_n++;
      last_hs = cyc;
    end
    if (out_last) last_cyc = cyc;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (!busy && done_cyc >= 0 && busy_low < 0)
      busy_low = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_out_last"}, out_last, 1'b0);
    chk1({tag, "_pe_stall"}, pe_stall, 1'b1);
  endtask

  // vmode 0: in_valid=1, 1: 1,0,1,0,1,1 then 1, 2: random
  task automatic run_job(input int cols, input int vmode,
                         input bit hold, input bit spur,
                         input int abort_at);
    int hold_left;
    bit hold_done;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_rec();
    cols_m = cols;
    cfg_cols = CW'(cols);
    start = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = -1;
    step();
    start = 1'b0;
    cfg_cols = CW'($urandom);
    hold_left = 0;
    hold_done = 0;
    for (int k = 0; k < 300; k++) begin
      if (cyc == abort_at) begin
        chk1("pre_rst_out_valid", out_valid, 1'b1);
        chk1("pre_rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (k < 6) ? pat[k] : 1'b1;
        default: in_valid = 1'($urandom);
      endcase
      ifm_d = PW'($urandom);
      start = spur && (cyc == 1);
      if (spur && cyc == 1) cfg_cols = CW'(7);
      if (hold && !hold_done && out_valid &&
          hold_left == 0) begin
        hold_left = 5;
        held = out_psum;
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_active = 1;
        hold_left--;
        if (hold_left == 0) hold_done = 1;
      end else begin
        hold_active = 0;
        out_ready = (vmode == 2) ? 1'($urandom) : 1'b1;
      end
      step();
      if (busy_low >= 0) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    hold_active = 0;
    chk1("job_timeout", busy_low >= 0, 1'b1);
  endtask

  task automatic job_checks(input int cols);
    chkn("accepts", acc_n, cols);
    chkn("handshakes", hs_n, cols);
    chkn("sb_left", exp_q.size(), 0);
    chkn("done_pulses", done_n, 1);
    chkn("busy_fall", busy_low, done_cyc + 1);
    if (cols > 0)
      chkn("done_after_last", done_cyc, last_hs + 1);
  endtask

  task automatic lat_checks(input int n);
    chkn("ov_count", ov_cyc.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < ov_cyc.size() && i < acc_cyc.size())
        chkn("ov_latency", ov_cyc[i], acc_cyc[i] + 3);
    end
  endtask

  initial begin
    // reset state
    #1;
    chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // streaming cols=4
    run_job(4, 0, 0, 0, -100);
    job_checks(4);
    lat_checks(4);
    chkn("t1_first_acc", acc_cyc.size() > 0 ? acc_cyc[0] : -1, 0);
    chkn("t1_last_cyc", last_cyc, 6);
    chkn("t1_done_cyc", done_cyc, 7);
    chkn("t1_busy_low", busy_low, 8);
    chk1("t1_no_stall", stall_run, 1'b0);
    step();

    // backpressure hold, cols=3
    run_job(3, 0, 1, 0, -100);
    job_checks(3);
    step();

    // bubbles, cols=4
    run_job(4, 1, 0, 0, -100);
    job_checks(4);
    lat_checks(4);
    chk1("t3_no_stall", stall_run, 1'b0);
    chkn("t3_done_cyc", done_cyc, 9);
    step();

    // zero-length job
    run_job(0, 0, 0, 0, -100);
    job_checks(0);
    chkn("t4_done_cyc", done_cyc, 0);
    chk1("t4_no_in_ready", ir_seen, 1'b0);
    chkn("t4_no_out_valid", ov_cyc.size(), 0);
    step();

    // reset during DRAIN, then clean cols=2 job
    run_job(4, 0, 0, 0, 5);
    step();
    chk_reset_outs("post_abort");
    run_job(2, 0, 0, 0, -100);
    job_checks(2);
    lat_checks(2);
    chkn("t5_done_cyc", done_cyc, 5);
    step();

    // spurious start during RUN
    run_job(3, 0, 0, 1, -100);
    job_checks(3);
    chkn("t6_done_cyc", done_cyc, 6);
    step();

    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      int c;
      c = int'($urandom_range(8, 1));
      run_job(c, 2, 0, 0, -100);
      job_checks(c);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
